// File: rtl/operand2_shift_seq.sv
// Iterative operand-2 shifter/rotator (imm8 ROR 2*rot4, or LSL/LSR/ASR/ROR of rm_val), STEP bits per cycle.
// Define OP2_FAST_IMM_EN to resolve immediates in a single cycle through a full rotator.
module operand2_shift_seq #(
   parameter int STEP = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   input  logic [7:0]  imm8,
   input  logic [3:0]  rot4,
   input  logic [31:0] rm_val,
   input  logic [1:0]  sh_type,
   input  logic [4:0]  sh_amt,
   input  logic        carry_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        carry_out
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [4:0] STEP_W = 5'(STEP);

   state_t      state, stateNext;
   logic [31:0] shVal;
   logic [1:0]  shType;
   logic [4:0]  remaining;
   logic        accept, goDone, lastStep;
   logic [31:0] ldVal, stepVal;
   logic [1:0]  ldType;
   logic [4:0]  ldAmt;
   logic        stepCarry;

   // An immediate is just a ROR by the doubled rotate field.
   assign ldVal    = mode ? rm_val  : {24'b0, imm8};
   assign ldType   = mode ? sh_type : 2'b11;
   assign ldAmt    = mode ? sh_amt  : {rot4, 1'b0};
   assign accept   = start && (state == IDLE);
   assign lastStep = (remaining <= STEP_W);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

`ifdef OP2_FAST_IMM_EN
   logic [31:0] rotVal;
   assign rotVal = (ldVal >> ldAmt) | (ldVal << (6'd32 - {1'b0, ldAmt}));
   assign goDone = (ldAmt == 5'd0) || !mode;
`else
   assign goDone = (ldAmt == 5'd0);
`endif

   // One STEP slice: up to STEP single-bit shifts, stopping when remaining runs out.
   always_comb begin
      stepVal   = shVal;
      stepCarry = 1'b0;
      for (int i = 0; i < STEP; i++) begin
         if (int'(remaining) > i) begin
            case (shType)
               2'b00:   begin stepCarry = stepVal[31]; stepVal = {stepVal[30:0], 1'b0}; end
               2'b01:   begin stepCarry = stepVal[0];  stepVal = {1'b0, stepVal[31:1]}; end
               2'b10:   begin stepCarry = stepVal[0];  stepVal = {stepVal[31], stepVal[31:1]}; end
               default: begin stepCarry = stepVal[0];  stepVal = {stepVal[0], stepVal[31:1]}; end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = goDone ? DONE : SHIFT;
         SHIFT:   if (lastStep) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shVal     <= '0;
         shType    <= '0;
         remaining <= '0;
         result    <= '0;
         carry_out <= 1'b0;
      end else if (accept) begin
         shVal     <= ldVal;
         shType    <= ldType;
         remaining <= ldAmt;
         // Zero amount passes the operand and C flag straight through.
         if (ldAmt == 5'd0) begin
            result    <= ldVal;
            carry_out <= carry_in;
         end
`ifdef OP2_FAST_IMM_EN
         else if (!mode) begin
            result    <= rotVal;
            carry_out <= rotVal[31];
            remaining <= '0;
         end
`endif
      end else if (state == SHIFT) begin
         shVal     <= stepVal;
         remaining <= lastStep ? 5'd0 : remaining - STEP_W;
         if (lastStep) begin
            result    <= stepVal;
            carry_out <= stepCarry;
         end
      end
   end
endmodule

// File: tb/tb_operand2_shift_seq.sv
// Scoreboard bench for operand2_shift_seq; drives a STEP=1 and a STEP=2 instance in lockstep.
module tb_operand2_shift_seq;
   logic        clk = 1'b0, reset;
   logic        start, mode, carry_in;
   logic [7:0]  imm8;
   logic [3:0]  rot4;
   logic [31:0] rm_val;
   logic [1:0]  sh_type;
   logic [4:0]  sh_amt;
   logic        busy1, done1, co1, busy2, done2, co2;
   logic [31:0] res1, res2;

   typedef struct {
      logic [31:0] res;
      logic        cy;
      int          n;
      logic        imm;
   } exp_t;

   exp_t sb[$];
   int   nTests = 0, nFail = 0;

   always #5 clk = ~clk;

   operand2_shift_seq #(.STEP(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .imm8(imm8), .rot4(rot4),
      .rm_val(rm_val), .sh_type(sh_type), .sh_amt(sh_amt), .carry_in(carry_in),
      .busy(busy1), .done(done1), .result(res1), .carry_out(co1));

   operand2_shift_seq #(.STEP(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .imm8(imm8), .rot4(rot4),
      .rm_val(rm_val), .sh_type(sh_type), .sh_amt(sh_amt), .carry_in(carry_in),
      .busy(busy2), .done(done2), .result(res2), .carry_out(co2));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference built from wide shifts rather than bit-serial steps.
   function automatic exp_t model(input logic m, input logic [7:0] i8, input logic [3:0] r4,
                                  input logic [31:0] rv, input logic [1:0] st,
                                  input logic [4:0] sa, input logic ci);
      exp_t        e;
      logic [31:0] v;
      logic [1:0]  t;
      logic [63:0] w;
      int          n;
      v = m ? rv : {24'b0, i8};
      t = m ? st : 2'b11;
      n = m ? int'(sa) : 2 * int'(r4);
      e.n = n; e.imm = !m;
      if (n == 0) begin
         e.res = v; e.cy = ci;
      end else begin
         case (t)
            2'b00: begin w = {32'b0, v} << n; e.res = w[31:0]; e.cy = w[32]; end
            2'b01: begin w = {v, 32'b0} >> n; e.res = w[63:32]; e.cy = w[31]; end
            2'b10: begin w = $signed({v, 32'b0}) >>> n; e.res = w[63:32]; e.cy = w[31]; end
            default: begin e.res = (v >> n) | (v << (32 - n)); e.cy = e.res[31]; end
         endcase
      end
      return e;
   endfunction

   function automatic int expLat(input exp_t e, input int step);
`ifdef OP2_FAST_IMM_EN
      if (e.imm) return 1;
`endif
      return (e.n + step - 1) / step + 1;
   endfunction

   // Called at a negedge; returns at a negedge after both instances finish.
   task automatic run(input string tag, input logic m, input logic [7:0] i8, input logic [3:0] r4,
                      input logic [31:0] rv, input logic [1:0] st, input logic [4:0] sa,
                      input logic ci, input logic poke);
      int   l1 = 0, l2 = 0;
      exp_t e;
      mode = m; imm8 = i8; rot4 = r4; rm_val = rv; sh_type = st; sh_amt = sa; carry_in = ci;
      start = 1'b1;
      sb.push_back(model(m, i8, r4, rv, st, sa, ci));
      @(posedge clk); #1;
      start = 1'b0;
      // Later input changes must not leak into the latched operation.
      imm8 = ~i8; rot4 = ~r4; rm_val = ~rv; sh_type = ~st; sh_amt = ~sa; carry_in = ~ci;
      e = sb.pop_front();
      for (int c = 1; c <= 40 && (l1 == 0 || l2 == 0); c++) begin
         @(negedge clk);
         if (done1 && l1 == 0) begin
            l1 = c;
            chk({tag, "/res1"}, 64'(res1), 64'(e.res));
            chk({tag, "/cy1"}, 64'(co1), 64'(e.cy));
         end
         if (done2 && l2 == 0) begin
            l2 = c;
            chk({tag, "/res2"}, 64'(res2), 64'(e.res));
            chk({tag, "/cy2"}, 64'(co2), 64'(e.cy));
         end
         if (poke && c == 2) begin
            start = 1'b1; mode = 1'b1; rm_val = 32'hDEADBEEF; sh_type = 2'b00; sh_amt = 5'd1;
         end else start = 1'b0;
      end
      chk({tag, "/lat1"}, 64'(l1), 64'(expLat(e, 1)));
      chk({tag, "/lat2"}, 64'(l2), 64'(expLat(e, 2)));
      @(negedge clk); @(negedge clk);
      chk({tag, "/hold1"}, {31'b0, co1, res1}, {31'b0, e.cy, e.res});
      chk({tag, "/idle"}, {62'b0, busy1, busy2}, 64'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; imm8 = '0; rot4 = '0;
      rm_val = '0; sh_type = '0; sh_amt = '0; carry_in = 1'b0;
      #12;
      chk("rst_state", {30'b0, busy1, done1, co1, res1}, 64'd0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);

      run("imm_ff_r4",  1'b0, 8'hFF, 4'd4, 32'h0,        2'b00, 5'd0,  1'b0, 1'b0);
      run("lsl1",       1'b1, 8'h00, 4'd0, 32'h80000001, 2'b00, 5'd1,  1'b0, 1'b0);
      run("asr31_poke", 1'b1, 8'h00, 4'd0, 32'h80000000, 2'b10, 5'd31, 1'b1, 1'b1);
      run("lsr4",       1'b1, 8'h00, 4'd0, 32'h0000000F, 2'b01, 5'd4,  1'b0, 1'b0);
      run("ror0",       1'b1, 8'h00, 4'd0, 32'h12345678, 2'b11, 5'd0,  1'b1, 1'b0);
      run("imm_r0_c1",  1'b0, 8'h5A, 4'd0, 32'h0,        2'b00, 5'd0,  1'b1, 1'b0);
      run("imm_r0_c0",  1'b0, 8'h5A, 4'd0, 32'h0,        2'b00, 5'd0,  1'b0, 1'b0);
      run("lsr3",       1'b1, 8'h00, 4'd0, 32'h0000000F, 2'b01, 5'd3,  1'b0, 1'b0);
      run("ror31",      1'b1, 8'h00, 4'd0, 32'h00000001, 2'b11, 5'd31, 1'b0, 1'b0);
      run("imm_r15",    1'b0, 8'h81, 4'd15, 32'h0,       2'b00, 5'd0,  1'b0, 1'b0);
      for (int k = 0; k < 8; k++)
         run($sformatf("rnd%0d", k), 1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom),
             $urandom, 2'($urandom), 5'($urandom), 1'($urandom), 1'b0);

      // Leave a nonzero result behind, then kill a long op mid-flight.
      run("pre_rst", 1'b1, 8'h00, 4'd0, 32'hF0000001, 2'b00, 5'd1, 1'b0, 1'b0);
      mode = 1'b1; rm_val = 32'hA5A5A5A5; sh_type = 2'b11; sh_amt = 5'd20; carry_in = 1'b1;
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst1", {30'b0, busy1, done1, co1, res1}, 64'd0);
      chk("async_rst2", {30'b0, busy2, done2, co2, res2}, 64'd0);
      @(negedge clk); reset = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (c == 24) chk("no_done_after_rst", {62'b0, done1, busy1}, 64'd0);
         else if (done1) chk("no_done_after_rst", 64'(done1), 64'd0);
      end
      run("post_rst", 1'b1, 8'h00, 4'd0, 32'h0000F000, 2'b01, 5'd12, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/operand2_shift_seq.md
Name: operand2_shift_seq

Overview:
- Multi-cycle sequencer for the ARM-style operand-2 path of the 32-bit core.
- Immediate mode: zero-extends an 8-bit immediate and rotates it right by 2×rot.
- Register mode: applies LSL/LSR/ASR/ROR to a register value by a 5-bit amount.
- Iterative shifter, STEP bits per cycle; start/busy/done handshake toward the execute-stage control FSM. Also produces the shifter carry-out for flag logic.

Parameters:
- STEP, 1, bits shifted per SHIFT cycle; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- mode  input  1  0 = immediate (imm8/rot4), 1 = register shift (rm_val/sh_type/sh_amt)
- imm8  input  8  immediate field
- rot4  input  4  rotate field; rotate amount = 2×rot4
- rm_val  input  32  register operand
- sh_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR (register mode only)
- sh_amt  input  5  shift amount 0–31 (register mode only)
- carry_in  input  1  current C flag
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; result/carry_out valid
- result  output  32  shifted operand, held until next accepted start
- carry_out  output  1  shifter carry, held with result

Behaviour:
- States:
  - IDLE → SHIFT on accepted start with amount ≠ 0.
  - IDLE → DONE on accepted start with amount = 0.
  - SHIFT → DONE when remaining ≤ STEP; otherwise stays in SHIFT.
  - DONE → IDLE unconditionally.
- On accept, operands are latched:
  - Immediate: value = {24'b0, imm8}, type = ROR, amount = {rot4, 1'b0}.
  - Register: value = rm_val, type = sh_type, amount = sh_amt.
- Each SHIFT cycle:
  - Shift by k = min(STEP, remaining) using the latched type; remaining -= k.
  - LSL/LSR fill with 0; ASR fills with value[31]; ROR wraps.
- carry_out:
  - Amount ≠ 0: the last bit shifted out in the final step. For ROR this equals result[31].
  - Amount = 0: carry_out = carry_in sampled at accept; result = value unchanged. No ARM special encodings (LSR #0 = #32, RRX) are supported.
- Latency: for amount N, done is high in cycle ceil(N/STEP)+1 after the accept edge. For N = 0, done is high 1 cycle after the accept edge.
- start while busy = 1 is ignored; no queueing.
- start with done high is also ignored, since busy is high in DONE.
- result and carry_out are stable from done until the next accept. They update only at the final SHIFT step, or at the accept edge when N = 0.
- Reset, asynchronous, any state:
  - Immediately: state = IDLE, busy = 0, done = 0, result = 0, carry_out = 0, remaining = 0.
  - Any in-flight operation is lost; no done is issued for it.
- Combinational inputs are sampled only at the accept edge; later changes have no effect.

Optional Feature:
- Macro: OP2_FAST_IMM_EN.
- Defined: immediate mode bypasses SHIFT. At accept, a full 32-bit rotator computes ({24'b0,imm8} ROR 2×rot4) and the state goes directly to DONE, so done is high 1 cycle after accept.
  - carry_out = result[31] if rot4 ≠ 0, else carry_in.
  - Register mode is unchanged.
- Undefined: immediate mode uses the iterative path, with latency per the formula above.
- Result values are identical in both builds.

Test Plan:
1. STEP=1, immediate, imm8=0xFF, rot4=4, carry_in=0 → result=0xFF000000, carry_out=1, done 9 cycles after accept. With OP2_FAST_IMM_EN, done 1 cycle after accept, same values.
2. Register LSL, rm_val=0x80000001, sh_amt=1 → result=0x00000002, carry_out=1, done 2 cycles after accept.
3. Register ASR, rm_val=0x80000000, sh_amt=31 → result=0xFFFFFFFF, carry_out=0. Register LSR, rm_val=0x0000000F, sh_amt=4 → result=0x00000000, carry_out=1.
4. Register ROR, rm_val=0x12345678, sh_amt=0, carry_in=1 → result=0x12345678, carry_out=1, done 1 cycle after accept. Immediate rot4=0, imm8=0x5A → result=0x0000005A, carry_out=carry_in.
5. STEP=2, register LSR, rm_val=0x0000000F, sh_amt=3 → 2 SHIFT cycles, result=0x00000001, carry_out=1, done 3 cycles after accept.
6. Assert reset in the 3rd SHIFT cycle → busy/done/result/carry_out go to 0 without waiting for a clock edge. Pulse start during busy → ignored, and the original result is unchanged at done. After reset release, a new start completes normally.
